// File: rtl/bldc_pkg.sv
// Shared types and constants for the BLDC dead-time gate driver.
package bldc_pkg;

    typedef enum logic [1:0] {
        StOff,
        StHi,
        StLo,
        StDead
    } phase_state_e;

    localparam int unsigned CntWidth      = 16;
    localparam int unsigned DefaultPhases = 3;

endpackage

// File: rtl/bldc_deadtime_if.sv
// Request/gate/fault bundle between the PWM stage (master) and the dead-time block (slave).
interface bldc_deadtime_if #(
    parameter int unsigned PHASES = bldc_pkg::DefaultPhases
) ();

    logic              enable;
    logic [PHASES-1:0] req_p;
    logic [PHASES-1:0] req_n;
    logic [PHASES-1:0] gate_p;
    logic [PHASES-1:0] gate_n;
    logic              fault;
    logic              fault_clr;
    logic [PHASES-1:0] fault_phase;

    modport master (
        output enable, req_p, req_n, fault_clr,
        input  gate_p, gate_n, fault, fault_phase
    );

    modport slave (
        input  enable, req_p, req_n, fault_clr,
        output gate_p, gate_n, fault, fault_phase
    );

endinterface

// File: rtl/bldc_deadtime_phase.sv
// One half-bridge: OFF/HI/LO/DEAD state machine with a dead-time down-counter and
// registered gate outputs.
module bldc_deadtime_phase
    import bldc_pkg::*;
#(
    parameter int unsigned DEADTIME = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic req_p,
    input  logic req_n,
    output logic gate_p,
    output logic gate_n
);

    localparam logic [CntWidth-1:0] Reload = CntWidth'(DEADTIME - 1);

    phase_state_e        state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                gate_p_q, gate_p_d;
    logic                gate_n_q, gate_n_d;
    logic                req_hi, req_lo;
    phase_state_e        off_next;

    always_comb begin
        // Both sides requested at once counts as no request.
        req_hi   = req_p & ~req_n;
        req_lo   = req_n & ~req_p;
        off_next = StOff;
        if (enable && req_hi) begin
            off_next = StHi;
        end else if (enable && req_lo) begin
            off_next = StLo;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StOff: state_d = off_next;
            StHi: begin
                if (!(enable && req_hi)) begin
                    state_d = StDead;
                    cnt_d   = Reload;
                end
            end
            StLo: begin
                if (!(enable && req_lo)) begin
                    state_d = StDead;
                    cnt_d   = Reload;
                end
            end
            StDead: begin
                if (cnt_q == '0) begin
                    state_d = off_next;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            default: begin
                state_d = StOff;
                cnt_d   = '0;
            end
        endcase

        gate_p_d = (state_d == StHi);
        gate_n_d = (state_d == StLo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StOff;
            cnt_q    <= '0;
            gate_p_q <= 1'b0;
            gate_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gate_p_q <= gate_p_d;
            gate_n_q <= gate_n_d;
        end
    end

    assign gate_p = gate_p_q;
    assign gate_n = gate_n_q;

endmodule

// File: rtl/bldc_deadtime.sv
// Multi-phase BLDC dead-time inserter with shoot-through detection.
// Optional DEADTIME_FAULT_LATCH_EN: sticky fault_phase cleared by fault_clr; fault disables gates.
module bldc_deadtime
    import bldc_pkg::*;
#(
    parameter int unsigned DEADTIME = 50,
    parameter int unsigned PHASES   = DefaultPhases
) (
    input  logic            clk,
    input  logic            rst_n,
    bldc_deadtime_if.slave  bus
);

    logic [PHASES-1:0] shoot;
    logic [PHASES-1:0] gate_p;
    logic [PHASES-1:0] gate_n;
    logic [PHASES-1:0] fault_phase_q, fault_phase_d;
    logic              fault_q, fault_d;
    logic              phase_en;

`ifdef DEADTIME_FAULT_LATCH_EN
    assign phase_en = bus.enable & ~fault_q;

    // A fresh shoot-through wins over a simultaneous clear.
    always_comb begin
        fault_phase_d = (fault_phase_q & {PHASES{~bus.fault_clr}}) | shoot;
        fault_d       = |fault_phase_d;
    end
`else
    logic unused_fault_clr;
    assign unused_fault_clr = bus.fault_clr;
    assign phase_en         = bus.enable;

    always_comb begin
        fault_phase_d = shoot;
        fault_d       = |fault_phase_d;
    end
`endif

    for (genvar i = 0; i < PHASES; i++) begin : g_phase
        assign shoot[i] = bus.req_p[i] & bus.req_n[i];

        bldc_deadtime_phase #(
            .DEADTIME (DEADTIME)
        ) u_phase (
            .clk    (clk),
            .rst_n  (rst_n),
            .enable (phase_en),
            .req_p  (bus.req_p[i]),
            .req_n  (bus.req_n[i]),
            .gate_p (gate_p[i]),
            .gate_n (gate_n[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_phase_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            fault_phase_q <= fault_phase_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.gate_p      = gate_p;
    assign bus.gate_n      = gate_n;
    assign bus.fault       = fault_q;
    assign bus.fault_phase = fault_phase_q;

endmodule

// File: tb/tb_bldc_deadtime.sv
// Directed bench for bldc_deadtime with DEADTIME=4, three phases; expected outputs are
// queued as each step is driven and checked after the sampling edge.
module tb_bldc_deadtime;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    bldc_deadtime_if #(.PHASES(3)) bus ();

    bldc_deadtime #(
        .DEADTIME (4),
        .PHASES   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // High and low gate of the same phase must never be on together.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert ((bus.gate_p & bus.gate_n) === 3'b000) else begin
                errors++;
                $error("FAIL overlap got=%b required=000", bus.gate_p & bus.gate_n);
            end
        end
    end

    task automatic push(input string tag, input logic [2:0] egp, input logic [2:0] egn,
                        input logic ef, input logic [2:0] efp);
        exp_q.push_back({egp, egn, ef, efp});
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        logic [9:0] obs;
        logic [9:0] exp_v;
        string      tag;
        obs = {bus.gate_p, bus.gate_n, bus.fault, bus.fault_phase};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty got=%b required=entry", obs);
        end else begin
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s got gp=%b gn=%b f=%b fp=%b required gp=%b gn=%b f=%b fp=%b",
                       tag, obs[9:7], obs[6:4], obs[3], obs[2:0],
                       exp_v[9:7], exp_v[6:4], exp_v[3], exp_v[2:0]);
            end
        end
    endtask

    task automatic step(input string tag, input logic en, input logic [2:0] rp,
                        input logic [2:0] rn, input logic clr, input logic [2:0] egp,
                        input logic [2:0] egn, input logic ef, input logic [2:0] efp);
        bus.enable    = en;
        bus.req_p     = rp;
        bus.req_n     = rn;
        bus.fault_clr = clr;
        push(tag, egp, egn, ef, efp);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.enable    = 1'b0;
        bus.req_p     = 3'b000;
        bus.req_n     = 3'b000;
        bus.fault_clr = 1'b0;
        #2;
        push("reset", 3'b000, 3'b000, 1'b0, 3'b000);
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;

        // U high side on with one cycle latency
        step("u_hi",   1'b1, 3'b001, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0, 3'b000);

        // HI -> LO: four blanked cycles, then low side
        step("dt1",    1'b1, 3'b000, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("dt2",    1'b1, 3'b000, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("dt3",    1'b1, 3'b000, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("dt4",    1'b1, 3'b000, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("u_lo",   1'b1, 3'b000, 3'b001, 1'b0, 3'b000, 3'b001, 1'b0, 3'b000);

        // Request returns during DEAD; blanking is not shortened
        step("rd1",    1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("rd2",    1'b1, 3'b001, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("rd3",    1'b1, 3'b001, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("rd4",    1'b1, 3'b001, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("u_hi2",  1'b1, 3'b001, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0, 3'b000);

        // Shoot-through request on V
        step("flt_on", 1'b1, 3'b011, 3'b010, 1'b0, 3'b001, 3'b000, 1'b1, 3'b010);
`ifdef DEADTIME_FAULT_LATCH_EN
        step("flt_hold", 1'b1, 3'b001, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 3'b010);
        step("clr_new",  1'b1, 3'b011, 3'b010, 1'b1, 3'b000, 3'b000, 1'b1, 3'b010);
        step("flt_clr",  1'b1, 3'b001, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 3'b000);
        step("clr_dead", 1'b1, 3'b001, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("clr_back", 1'b1, 3'b001, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0, 3'b000);
`else
        step("flt_drop", 1'b1, 3'b001, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0, 3'b000);
`endif

        // All phases active, then disable for two cycles and re-enable
        step("all_on", 1'b1, 3'b011, 3'b100, 1'b0, 3'b011, 3'b100, 1'b0, 3'b000);
        step("dis1",   1'b0, 3'b011, 3'b100, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("dis2",   1'b0, 3'b011, 3'b100, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("ren1",   1'b1, 3'b011, 3'b100, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("ren2",   1'b1, 3'b011, 3'b100, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        step("ren_on", 1'b1, 3'b011, 3'b100, 1'b0, 3'b011, 3'b100, 1'b0, 3'b000);

        // U/V enter DEAD while W stays low-side; reset mid-count
        step("w_hold1", 1'b1, 3'b000, 3'b100, 1'b0, 3'b000, 3'b100, 1'b0, 3'b000);
        step("w_hold2", 1'b1, 3'b000, 3'b100, 1'b0, 3'b000, 3'b100, 1'b0, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        push("async_rst", 3'b000, 3'b000, 1'b0, 3'b000);
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bldc_deadtime.md
BLDC_DEADTIME -- requirements
Module: bldc_deadtime

Interface
REQ-001 SHALL have parameter DEADTIME, default 50: blanking time in clk cycles, legal range 1..65535.
REQ-002 SHALL have parameter PHASES, default 3: number of half-bridges.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: gate enable.
REQ-006 SHALL have port req_p, input, PHASES bits: high-side requests from the sine PWM stage, bit0=U, bit1=V, bit2=W.
REQ-007 SHALL have port req_n, input, PHASES bits: low-side requests, same ordering.
REQ-008 SHALL have port gate_p, output, PHASES bits: registered high-side gate drive.
REQ-009 SHALL have port gate_n, output, PHASES bits: registered low-side gate drive.
REQ-010 SHALL have port fault, output, 1 bit: shoot-through request indication.
REQ-011 SHALL have port fault_clr, input, 1 bit: clears a latched fault.
REQ-012 SHALL have port fault_phase, output, PHASES bits: phases that caused the fault.

Function
REQ-013 Each phase SHALL run an independent FSM with states OFF, HI, LO and DEAD.
- OFF: both gates low.
- HI: gate_p high.
- LO: gate_n high.
- DEAD: both gates low while a 16-bit down-counter runs.
REQ-014 Transitions out of OFF: req_p only -> HI; req_n only -> LO; neither or both -> stay in OFF.
REQ-015 HI SHALL be held while req_p=1 and req_n=0; any other input moves HI to DEAD with the counter loaded to DEADTIME-1.
REQ-016 LO behaves like HI with the roles of req_p and req_n swapped.
REQ-017 DEAD SHALL decrement each cycle. At count 0 the next state is chosen by the OFF rules, so dead time is exactly DEADTIME cycles of both gates low.
REQ-018 Latency from a request in OFF to the gate SHALL be 1 cycle (registered); gate_p and gate_n of one phase SHALL never be high in the same cycle.
REQ-019 A request arriving during DEAD SHALL NOT shorten DEAD; the requested side is driven on the cycle after the count reaches 0.
REQ-020 req_p=req_n=1 in any state SHALL be treated as no request and SHALL set fault_phase[i] for that phase.
REQ-021 enable=0 SHALL force every phase in HI or LO to DEAD with a full reload; phases in OFF stay in OFF; DEAD keeps counting.
REQ-022 On re-enable, output is held off until dead time expires, so no gate turns on without preceding blanking.
REQ-023 fault SHALL equal the OR of fault_phase, registered, with 1-cycle latency from the offending request.
REQ-024 fault_clr and a new fault in the same cycle: the new fault wins.

Reset
REQ-025 While rst_n=0, all FSMs SHALL be in OFF, counters 0, gate_p=gate_n=0, fault=0 and fault_phase=0, asynchronously.
REQ-026 Reset deasserted mid-DEAD (reset asserted during DEAD) SHALL abandon the count; after release phases start in OFF.
REQ-027 Reset release SHALL be used only synchronously internally.

Configuration
REQ-028 With DEADTIME_FAULT_LATCH_EN defined, fault_phase bits SHALL be sticky until fault_clr=1.
REQ-029 While fault=1 with the macro defined, all phases SHALL behave as enable=0.
REQ-030 Without DEADTIME_FAULT_LATCH_EN, fault_phase SHALL mirror the current cycle's shoot-through condition (registered) and fault_clr SHALL be ignored.

Structure
REQ-031 Package bldc_pkg SHALL hold:
- the phase-state enumeration (OFF, HI, LO, DEAD);
- the dead-counter width constant (16);
- the default phase count constant (3).
REQ-032 Per-phase FSM and counter SHALL be a sub-module bldc_deadtime_phase, instantiated PHASES times by a generate loop; fault aggregation stays in the top.

Verification (DEADTIME=4)
REQ-033 Reset, then req_p=001, enable=1 -> gate_p[0]=1 one cycle later; gate_n=000; fault=0.
REQ-034 Phase U in HI, switch to req_p=0/req_n=1 -> exactly 4 cycles with both U gates low, then gate_n[0]=1 on cycle 5.
REQ-035 In DEAD, toggle req_p back to 1 after 1 cycle -> DEAD still lasts 4 cycles, then gate_p[0]=1.
REQ-036 Assert req_p[1]=req_n[1]=1 -> V gates stay low; fault=1 and fault_phase=010 next cycle. With the macro defined, all gates are off until fault_clr; without it, fault drops one cycle after the condition ends.
REQ-037 Drop enable while all three phases are active -> all gates low next cycle. Re-enable after 2 cycles -> gates return only after the 4-cycle dead time completes.
REQ-038 Assert rst_n=0 mid-DEAD -> outputs are 0 immediately. After release with req_n=100 -> gate_n[2]=1 after 1 cycle, with no residual dead count.
